// File: rtl/vec_decode.sv
// Vector instruction decode stage: single-entry hold register, legality check,
// and a per-register writeback scoreboard that gates issue on pending writes.

module vec_decode_sb_bit (
  input  logic CLK_DC,
  input  logic RST,
  input  logic set,
  input  logic clr,
  output logic pend
);
  // Set has priority so an issue that targets a register whose previous write
  // completes on the same edge still leaves the new write pending.
  always_ff @(posedge CLK_DC or negedge RST)
    if (!RST)     pend <= 1'b0;
    else if (set) pend <= 1'b1;
    else if (clr) pend <= 1'b0;
endmodule

module vec_decode #(
  parameter int REGS = 6
) (
  input  logic        RST,
  input  logic        CLK_DC,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] INSTR,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [4:0]  A1,
  output logic [4:0]  A2,
  output logic [4:0]  A3,
  output logic [2:0]  OP,
  output logic        WE,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_A3,
  input  logic        FLUSH,
  output logic        ILLEGAL,
  output logic        BUSY,
  output logic [15:0] STALL_CNT
);
  localparam logic [6:0] OPC_VEC = 7'b0001011;
  localparam logic [5:0] NREGS   = 6'(REGS);

  typedef struct packed {
    logic [6:0] hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [6:0] opc;
  } vinstr_t;

  typedef enum logic [1:0] {IDLE, HOLD, ISSUE} state_t;

  state_t          state;
  vinstr_t         iq;
  logic [REGS-1:0] sb, sb_set, sb_clr;
  logic [31:0]     sb_eff;
  logic            uses_rs2, legal, hazard, fire;
  logic            unused_hi;

  assign unused_hi = ^iq.hi;
  assign IN_READY  = (state == IDLE);
  assign BUSY      = |sb;

  // Hazard is judged against the scoreboard with this cycle's writeback
  // already retired, so a dependent op issues on the edge its source frees.
  always_comb begin
    uses_rs2 = (iq.f3 != 3'd5);
    legal    = (iq.opc == OPC_VEC) && (iq.f3 <= 3'd5)
            && ({1'b0, iq.rs1} < NREGS) && ({1'b0, iq.rd} < NREGS)
            && (!uses_rs2 || ({1'b0, iq.rs2} < NREGS));
    sb_eff           = '0;
    sb_eff[REGS-1:0] = sb & ~sb_clr;
    hazard = sb_eff[iq.rs1] | (uses_rs2 & sb_eff[iq.rs2]) | sb_eff[iq.rd];
    fire   = (state == HOLD) && legal && !hazard && !FLUSH;
  end

  for (genvar i = 0; i < REGS; i++) begin : g_sb
    assign sb_set[i] = fire && (iq.rd == 5'(i));
    assign sb_clr[i] = WB_VALID && (WB_A3 == 5'(i));
    vec_decode_sb_bit u_bit (
      .CLK_DC(CLK_DC),
      .RST   (RST),
      .set   (sb_set[i]),
      .clr   (sb_clr[i]),
      .pend  (sb[i])
    );
  end

  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      iq        <= '0;
      OUT_VALID <= 1'b0;
      ILLEGAL   <= 1'b0;
      A1        <= '0;
      A2        <= '0;
      A3        <= '0;
      OP        <= '0;
      WE        <= 1'b0;
      STALL_CNT <= '0;
    end else begin
      ILLEGAL <= 1'b0;
      if (FLUSH) begin
        state     <= IDLE;
        OUT_VALID <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (IN_VALID) begin
            iq    <= INSTR;
            state <= HOLD;
          end
          HOLD: if (!legal) begin
            ILLEGAL <= 1'b1;
            state   <= IDLE;
          end else if (hazard) begin
            if (STALL_CNT != 16'hFFFF) STALL_CNT <= STALL_CNT + 16'd1;
          end else begin
            A1        <= iq.rs1;
            A2        <= uses_rs2 ? iq.rs2 : 5'd0;
            A3        <= iq.rd;
            OP        <= iq.f3;
            WE        <= 1'b1;
            OUT_VALID <= 1'b1;
            state     <= ISSUE;
          end
          ISSUE: if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
